// File: rtl/core_pkg.sv
// Shared types and constants for the core's program-counter logic.
package core_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALTED  = 2'd2
  } pc_state_t;

  localparam int          XLEN_DEFAULT         = 64;
  localparam int          INST_BYTES_DEFAULT   = 4;
  localparam int          CAUSE_W_DEFAULT      = 4;
  localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0;
  localparam logic [63:0] TRAP_VECTOR_DEFAULT  = 64'h100;

  // Cause reported when the selected next PC is not instruction-aligned.
  localparam logic [3:0]  CAUSE_MISALIGNED     = 4'hF;

endpackage

// File: rtl/pc_unit_if.sv
// Control and status bundle between decode/ALU, the PC unit and fetch.
interface pc_unit_if
  import core_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int CAUSE_W = CAUSE_W_DEFAULT
) ();

  logic               stall;
  logic               branch;
  logic               zero;
  logic               jal;
  logic               jalr;
  logic [XLEN-1:0]    imm;
  logic [XLEN-1:0]    rs1_value;
  logic               trap;
  logic [CAUSE_W-1:0] trap_cause;
  logic               trap_return;

  logic [XLEN-1:0]    pc_current;
  logic [XLEN-1:0]    pc_link;
  logic [XLEN-1:0]    epc;
  logic [CAUSE_W-1:0] cause;
  pc_state_t          state;
  logic               halted;

  // Decode side: drives control and targets, observes the PC and trap status.
  modport master (
    output stall, branch, zero, jal, jalr, imm, rs1_value,
           trap, trap_cause, trap_return,
    input  pc_current, pc_link, epc, cause, state, halted
  );

  // PC unit side.
  modport slave (
    input  stall, branch, zero, jal, jalr, imm, rs1_value,
           trap, trap_cause, trap_return,
    output pc_current, pc_link, epc, cause, state, halted
  );

endinterface

// File: rtl/pc_unit_next_sel.sv
// Combinational next-PC candidate generation, priority mux and alignment check.
module pc_next_sel
  import core_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int INST_BYTES = INST_BYTES_DEFAULT
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_value_i,
  input  logic            branch_i,
  input  logic            zero_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  output logic [XLEN-1:0] seq_o,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  // INST_BYTES is a power of two, so the low bits below it must all be zero.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);

  logic [XLEN-1:0] br;
  logic [XLEN-1:0] jrSum;
  logic [XLEN-1:0] jr;

  assign seq_o = pc_i + STEP;
  assign br    = pc_i + imm_i;
  assign jrSum = rs1_value_i + imm_i;
  assign jr    = {jrSum[XLEN-1:1], 1'b0};

  // Priority: register jump, then PC-relative jump, then taken branch, else fall through.
  always_comb begin
    target_o = seq_o;
    if (jalr_i) begin
      target_o = jr;
    end else if (jal_i) begin
      target_o = br;
    end else if (branch_i && zero_i) begin
      target_o = br;
    end
    misaligned_o = (target_o & ALIGN_MASK) != '0;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with jumps, trap entry/return and a run/handler/halted FSM.
module pc_unit
  import core_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
  parameter int              INST_BYTES   = INST_BYTES_DEFAULT,
  parameter int              CAUSE_W      = CAUSE_W_DEFAULT
) (
  input logic    clock,
  input logic    reset,
  pc_unit_if.slave bus
);

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  pc_state_t          state_q, state_d;

  logic [XLEN-1:0]    seq;
  logic [XLEN-1:0]    target;
  logic               misaligned;
  logic               fault;

  pc_next_sel #(
    .XLEN       (XLEN),
    .INST_BYTES (INST_BYTES)
  ) u_next_sel (
    .pc_i         (pc_q),
    .imm_i        (bus.imm),
    .rs1_value_i  (bus.rs1_value),
    .branch_i     (bus.branch),
    .zero_i       (bus.zero),
    .jal_i        (bus.jal),
    .jalr_i       (bus.jalr),
    .seq_o        (seq),
    .target_o     (target),
    .misaligned_o (misaligned)
  );

  // A misaligned target behaves exactly like an external trap request.
  assign fault = bus.trap | misaligned;

  // Next-state logic: faults beat stall, stall beats return and normal steering.
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (fault) begin
          epc_d   = pc_q;
          cause_d = bus.trap ? bus.trap_cause : CAUSE_W'(CAUSE_MISALIGNED);
          pc_d    = TRAP_VECTOR;
          state_d = HANDLER;
        end else if (!bus.stall) begin
          pc_d = target;
        end
      end
      HANDLER: begin
        if (fault) begin
          state_d = HALTED;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.trap_return) begin
          pc_d    = epc_q;
          state_d = RUN;
        end else begin
          pc_d = target;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  // State register with synchronous reset taking precedence over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      cause_q <= '0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      state_q <= state_d;
    end
  end

  assign bus.pc_current = pc_q;
  assign bus.pc_link    = seq;
  assign bus.epc        = epc_q;
  assign bus.cause      = cause_q;
  assign bus.state      = state_q;
  assign bus.halted     = (state_q == HALTED);

endmodule
